// File: rtl/fifo_pkg.sv
// Shared definitions for the nibble FIFO and its packing consumer:
// entry width, default pack size and the packer state encoding.
package fifo_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int PACK_COUNT = 4;
  localparam int CNT_WIDTH  = 3;

  localparam logic [1:0] REQ_IDLE = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] CHK      = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

endpackage

// File: rtl/pack_shift_reg.sv
// Slot storage for the packer: indexed write of one entry, bulk clear,
// and all slots presented as one word with slot 0 in the low bits.
module pack_shift_reg #(
  parameter int data_width = 4,
  parameter int pack_count = 4,
  parameter int cnt_width  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [cnt_width-1:0]             wr_idx,
  input  logic [data_width-1:0]            wr_data,
  input  logic                             clr,
  output logic [data_width*pack_count-1:0] word
);

  logic [pack_count-1:0][data_width-1:0] slots;

  // NOTE: the slots are reset even though they are storage, because a reset
  // must visibly clear any partial word and unused slots must read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots <= '0;
    end else if (clr) begin
      slots <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < pack_count; i++) begin
        if (wr_idx == cnt_width'(i)) slots[i] <= wr_data;
      end
    end
  end

  assign word = slots;

endmodule

// File: rtl/fifo_nibble_packer.sv
// Drains the nibble FIFO one entry per two cycles and packs entries into a
// wide word behind a valid/ready handshake. Optional: PACK_TIMEOUT_EN.
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int pack_count = PACK_COUNT,
  parameter int cnt_width  = CNT_WIDTH
`ifdef PACK_TIMEOUT_EN
  ,
  parameter int timeout_cycles = 16
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [data_width-1:0]            fifo_data,
  input  logic                             fifo_underflow,
  output logic                             re,
  input  logic                             flush,
  output logic [data_width*pack_count-1:0] word_out,
  output logic [cnt_width-1:0]             word_len,
  output logic                             word_valid,
  input  logic                             word_ready
);

  logic [1:0]           state, state_nxt;
  logic [cnt_width-1:0] cnt, cnt_nxt, cnt_inc, len_nxt;
  logic                 flush_pend, pend_nxt, valid_nxt;
  logic                 wr_en, clr, close_req, timeout_hit;

  assign cnt_inc   = cnt + 1'b1;
  assign close_req = flush | flush_pend | timeout_hit;

`ifdef PACK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(timeout_cycles + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_step;

  // Only empty polls made while a partial word is waiting count as idle time.
  assign idle_step   = (state == CHK) && fifo_underflow && (cnt != '0);
  assign timeout_hit = idle_step && (idle_cnt + 1'b1 == IDLE_W'(timeout_cycles));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (clr || ((state == CHK) && !fifo_underflow)) begin
      idle_cnt <= '0;
    end else if (idle_step) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so that no path
  // through the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = flush_pend;
    len_nxt   = word_len;
    valid_nxt = word_valid;
    wr_en     = 1'b0;
    clr       = 1'b0;
    case (state)
      REQ_IDLE: state_nxt = REQ;
      REQ: begin
        state_nxt = CHK;
        if (flush && cnt != '0) pend_nxt = 1'b1;
      end
      CHK: begin
        if (fifo_underflow) begin
          // A pending close with nothing new arriving ships what is held.
          if (close_req && cnt != '0) begin
            state_nxt = HOLD;
            len_nxt   = cnt;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end else begin
          wr_en   = 1'b1;
          cnt_nxt = cnt_inc;
          if (cnt_inc == cnt_width'(pack_count) || close_req) begin
            state_nxt = HOLD;
            len_nxt   = cnt_inc;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          clr       = 1'b1;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= REQ_IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      word_len   <= '0;
      word_valid <= 1'b0;
      re         <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      flush_pend <= pend_nxt;
      word_len   <= len_nxt;
      word_valid <= valid_nxt;
      re         <= (state_nxt == REQ);
    end
  end

  pack_shift_reg #(
    .data_width (data_width),
    .pack_count (pack_count),
    .cnt_width  (cnt_width)
  ) u_slots (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (cnt),
    .wr_data (fifo_data),
    .clr     (clr),
    .word    (word_out)
  );

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Directed bench for fifo_nibble_packer with a small behavioural FIFO that
// answers each read on the falling edge of the cycle re is high.
module tb_fifo_nibble_packer;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  fifo_data = '0;
  logic        fifo_underflow = 1'b0;
  logic        re;
  logic        flush = 1'b0;
  logic [15:0] word_out;
  logic [2:0]  word_len;
  logic        word_valid;
  logic        word_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] mem [16];
  int fifo_len    = 0;
  int force_empty = 0;
  int rd_ptr      = 0;
  int empties     = 0;
  int re_seen     = 0;

  always #5 clk = ~clk;

  fifo_nibble_packer dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_data      (fifo_data),
    .fifo_underflow (fifo_underflow),
    .re             (re),
    .flush          (flush),
    .word_out       (word_out),
    .word_len       (word_len),
    .word_valid     (word_valid),
    .word_ready     (word_ready)
  );

  // Forced empty reads come first, then the preloaded entries in order.
  always @(negedge clk) begin
    if (!rst) begin
      rd_ptr  = 0;
      empties = 0;
    end else if (re) begin
      if (empties < force_empty || rd_ptr >= fifo_len) begin
        fifo_underflow = 1'b1;
        if (empties < force_empty) empties++;
      end else begin
        fifo_underflow = 1'b0;
        fifo_data      = mem[rd_ptr];
        rd_ptr++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    flush       = 1'b0;
    fifo_len    = 0;
    force_empty = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] w);
    for (int i = 0; i < 4; i++) mem[i] = w[4*i +: 4];
    fifo_len = 4;
  endtask

  // Step negedges until word_valid or the cycle budget runs out.
  task automatic wait_word(inout int cyc);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (re) re_seen++;
      if (word_valid) seen = 1;
    end
  endtask

  initial begin
    int cyc;
    int bad_hold;
    logic [15:0] held;

    // Reset state
    do_reset();
    check("rst_re", re, 0);
    check("rst_valid", word_valid, 0);
    check("rst_word", word_out, 0);
    check("rst_len", word_len, 0);

    // Four entries, always ready
    preload(16'h8a41);
    rst = 1'b1; cyc = 0; re_seen = 0;
    wait_word(cyc);
    check("t1_valid", word_valid, 1);
    check("t1_cycles", cyc, 9);
    check("t1_re_pulses", re_seen, 4);
    check("t1_word", word_out, 16'h8a41);
    check("t1_len", word_len, 4);
    @(negedge clk);
    check("t1_valid_drop", word_valid, 0);
    check("t1_re_resume", re, 1);

    // Three underflow retries before the data appears
    do_reset();
    preload(16'h8a41);
    force_empty = 3;
    rst = 1'b1; cyc = 0;
    wait_word(cyc);
    check("t2_cycles", cyc, 15);
    check("t2_word", word_out, 16'h8a41);
    check("t2_len", word_len, 4);

    // Flush after two entries, FIFO then empty
    do_reset();
    mem[0] = 4'hc; mem[1] = 4'h5; fifo_len = 2;
    rst = 1'b1; cyc = 0;
    repeat (5) @(negedge clk);
    cyc = 5;
    flush = 1'b1;
    @(negedge clk);
    cyc++;
    flush = 1'b0;
    wait_word(cyc);
    check("t3_cycles", cyc, 7);
    check("t3_word", word_out, 16'h005c);
    check("t3_len", word_len, 2);

    // Flush with an empty word is ignored
    do_reset();
    preload(16'h7e2d);
    rst = 1'b1; cyc = 0;
    @(negedge clk);
    cyc = 1;
    flush = 1'b1;
    @(negedge clk);
    cyc++;
    flush = 1'b0;
    wait_word(cyc);
    check("t3b_cycles", cyc, 9);
    check("t3b_word", word_out, 16'h7e2d);
    check("t3b_len", word_len, 4);

    // Back-pressure in HOLD, flush during HOLD ignored
    do_reset();
    preload(16'hf123);
    word_ready = 1'b0;
    rst = 1'b1; cyc = 0;
    wait_word(cyc);
    check("t4_valid", word_valid, 1);
    held = 16'hf123;
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      flush = (i == 3);
      @(negedge clk);
      if (!word_valid || re || word_out !== held || word_len !== 3'd4) bad_hold++;
    end
    flush = 1'b0;
    check("t4_hold_stable", bad_hold, 0);
    word_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", word_valid, 0);
    check("t4_re_resume", re, 1);
    check("t4_slots_cleared", word_out, 0);

    // Reset with a partial word of two entries
    do_reset();
    preload(16'hdb69);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_partial", word_out, 16'h0069);
    rst = 1'b0;
    #1;
    check("t5_re_async", re, 0);
    check("t5_valid_async", word_valid, 0);
    check("t5_slots_async", word_out, 0);
    do_reset();
    preload(16'h4321);
    rst = 1'b1; cyc = 0;
    wait_word(cyc);
    check("t5_restart_cycles", cyc, 9);
    check("t5_restart_word", word_out, 16'h4321);

    // Reset while holding a word drops it immediately
    do_reset();
    preload(16'h5555);
    word_ready = 1'b0;
    rst = 1'b1; cyc = 0;
    wait_word(cyc);
    check("t6_valid", word_valid, 1);
    rst = 1'b0;
    #1;
    check("t6_valid_async", word_valid, 0);
    check("t6_word_async", word_out, 0);
    word_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
